// File: rtl/uart_transmitter.sv
// uart_transmitter: valid/ready byte in, UART frame out (start, DATA_WIDTH bits LSB first,
// optional parity, stop). Define UART_TX_BUF_EN to add a one-entry holding register.
module uart_transmitter #(
   parameter int CLK_FRE     = 100,
   parameter int DATA_WIDTH  = 8,
   parameter int PARITY_ON   = 0,
   parameter int PARITY_TYPE = 0,
   parameter int BAUD_RATE   = 9600
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst,
   input  logic                  i_tx_valid,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic                  o_tx_ready,
   output logic                  o_uart_tx,
   output logic                  o_tx_busy,
   output logic                  o_tx_done
);
   localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
   localparam logic [31:0] BAUD_MAX = 32'(CYCLE - 1);
   localparam logic [3:0]  BIT_MAX  = 4'(DATA_WIDTH - 1);
   localparam logic        PAR_ODD  = (PARITY_TYPE != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           baud_cnt_q, baud_cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef UART_TX_BUF_EN
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_full_q, hold_full_d;
   logic                  take_input;
`endif

   logic                  accept;
   logic                  bit_end;
   logic                  frame_slot;
   logic                  start_frame;
   logic [DATA_WIDTH-1:0] next_byte;

   assign accept  = i_tx_valid && ready_q;
   assign bit_end = (baud_cnt_q == BAUD_MAX);

   always_comb begin
      // NOTE: every _d gets its default first so no path through the case can infer a latch.
      state_d     = state_q;
      baud_cnt_d  = (state_q == S_IDLE || bit_end) ? '0 : baud_cnt_q + 32'd1;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      par_d       = par_q;
      tx_d        = tx_q;
      done_d      = 1'b0;
      frame_slot  = 1'b0;
      start_frame = 1'b0;
      next_byte   = i_tx_data;
`ifdef UART_TX_BUF_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      take_input  = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            tx_d       = 1'b1;
            frame_slot = 1'b1;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == BIT_MAX) begin
                  bit_cnt_d = '0;
                  if (PARITY_ON != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  tx_d      = shift_q[0];
                  shift_d   = shift_q >> 1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d    = S_IDLE;
               tx_d       = 1'b1;
               done_d     = 1'b1;
               frame_slot = 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            tx_d       = 1'b1;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase

      // A frame may begin from IDLE or straight out of STOP; the holding register has priority.
      if (frame_slot) begin
`ifdef UART_TX_BUF_EN
         if (hold_full_q) begin
            start_frame = 1'b1;
            next_byte   = hold_q;
            hold_full_d = 1'b0;
         end else if (accept) begin
            start_frame = 1'b1;
            take_input  = 1'b1;
         end
`else
         if (accept) start_frame = 1'b1;
`endif
      end

      if (start_frame) begin
         state_d    = S_START;
         tx_d       = 1'b0;
         shift_d    = next_byte;
         par_d      = (^next_byte) ^ PAR_ODD;
         baud_cnt_d = '0;
         bit_cnt_d  = '0;
      end

`ifdef UART_TX_BUF_EN
      if (accept && !take_input) begin
         hold_d      = i_tx_data;
         hold_full_d = 1'b1;
      end
      ready_d = !hold_full_d;
`else
      ready_d = (state_d == S_IDLE);
`endif
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      // NOTE: non-blocking only; every flop, shift register included, is reset so the line idles high.
      if (i_rst) begin
         state_q     <= S_IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tx_q        <= 1'b1;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef UART_TX_BUF_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tx_q        <= tx_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef UART_TX_BUF_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   assign o_uart_tx  = tx_q;
   assign o_tx_ready = ready_q;
   assign o_tx_busy  = busy_q;
   assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (8N1, 8E1, 8O1) at a short bit time,
// each line sample compared against a per-bit frame model.
module tb_uart_transmitter;
   localparam int CLK_FRE = 1;
   localparam int BAUD    = 200000;
   localparam int CYC     = CLK_FRE * 1000000 / BAUD;
`ifdef UART_TX_BUF_EN
   localparam logic RDY_MID = 1'b1;
   localparam bit   BUF     = 1'b1;
`else
   localparam logic RDY_MID = 1'b0;
   localparam bit   BUF     = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] valid;
   logic [7:0] data [3];
   logic [2:0] ready, tx, busy, done;
   int         checks;
   int         failures;

   always #5 clk = ~clk;

   uart_transmitter #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(8), .PARITY_ON(0), .PARITY_TYPE(0), .BAUD_RATE(BAUD))
      u_dut0 (.i_clk_sys(clk), .i_rst(rst), .i_tx_valid(valid[0]), .i_tx_data(data[0]),
              .o_tx_ready(ready[0]), .o_uart_tx(tx[0]), .o_tx_busy(busy[0]), .o_tx_done(done[0]));
   uart_transmitter #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(0), .BAUD_RATE(BAUD))
      u_dut1 (.i_clk_sys(clk), .i_rst(rst), .i_tx_valid(valid[1]), .i_tx_data(data[1]),
              .o_tx_ready(ready[1]), .o_uart_tx(tx[1]), .o_tx_busy(busy[1]), .o_tx_done(done[1]));
   uart_transmitter #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(8), .PARITY_ON(1), .PARITY_TYPE(1), .BAUD_RATE(BAUD))
      u_dut2 (.i_clk_sys(clk), .i_rst(rst), .i_tx_valid(valid[2]), .i_tx_data(data[2]),
              .o_tx_ready(ready[2]), .o_uart_tx(tx[2]), .o_tx_busy(busy[2]), .o_tx_done(done[2]));

   function automatic int pon(int k);
      return (k == 0) ? 0 : 1;
   endfunction

   function automatic int pty(int k);
      return (k == 2) ? 1 : 0;
   endfunction

   function automatic int flen(int k);
      return (10 + pon(k)) * CYC;
   endfunction

   // Expected line level t clocks after the accept edge (idle-high beyond the frame).
   function automatic logic exp_line(int k, logic [7:0] b, int t);
      int idx;
      idx = t / CYC;
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
      if (pon(k) == 1 && idx == 9) return ((($countones(b) + pty(k)) % 2) == 1);
      return 1'b1;
   endfunction

   function automatic logic exp_b2b(int t, int s2);
      if (t < s2) return exp_line(0, 8'h3C, t);
      return exp_line(0, 8'hC3, t - s2);
   endfunction

   // Offer one byte, then compare every clock of the frame; data is scrambled after accept.
   task automatic send_frame(input int k, input logic [7:0] b);
      int n;
      int fl;
      fl = flen(k);
      n  = 0;
      @(negedge clk);
      while (!ready[k] && n < 4 * fl) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ready[k] !== 1'b1) begin
         failures++;
         $display("FAIL ready_timeout dut%0d: ready=%b required 1", k, ready[k]);
         return;
      end
      data[k]  = b;
      valid[k] = 1'b1;
      @(posedge clk);
      #1 valid[k] = 1'b0;
      for (int t = 0; t <= fl; t++) begin
         @(negedge clk);
         data[k] = 8'($urandom);
         checks++;
         if (tx[k] !== exp_line(k, b, t)) begin
            failures++;
            $display("FAIL line dut%0d byte=%h t=%0d: got %b required %b", k, b, t, tx[k], exp_line(k, b, t));
         end
         checks++;
         if (done[k] !== (t == fl)) begin
            failures++;
            $display("FAIL done dut%0d byte=%h t=%0d: got %b required %b", k, b, t, done[k], (t == fl));
         end
         checks++;
         if (busy[k] !== (t < fl)) begin
            failures++;
            $display("FAIL busy dut%0d byte=%h t=%0d: got %b required %b", k, b, t, busy[k], (t < fl));
         end
         checks++;
         if (ready[k] !== ((t == fl) ? 1'b1 : RDY_MID)) begin
            failures++;
            $display("FAIL ready dut%0d byte=%h t=%0d: got %b required %b", k, b, t, ready[k],
                     (t == fl) ? 1'b1 : RDY_MID);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({tx[k], ready[k], busy[k], done[k]} !== 4'b1100) begin
            failures++;
            $display("FAIL reset dut%0d: tx/ready/busy/done=%b required 1100", k,
                     {tx[k], ready[k], busy[k], done[k]});
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_frames;
      logic [7:0] fixed [4];
      fixed = '{8'hA5, 8'h00, 8'hFF, 8'h5A};
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) send_frame(k, fixed[i]);
         for (int i = 0; i < 4; i++) send_frame(k, 8'($urandom));
      end
   endtask

   // Valid held high across two bytes: exactly two frames, no loss or duplication.
   task automatic test_back_to_back;
      int fl, s2, drop_t;
      fl     = flen(0);
      s2     = BUF ? fl : fl + 1;
      drop_t = BUF ? 1 : s2;
      @(negedge clk);
      checks++;
      if (ready[0] !== 1'b1) begin
         failures++;
         $display("FAIL b2b_idle_ready: got %b required 1", ready[0]);
      end
      data[0]  = 8'h3C;
      valid[0] = 1'b1;
      @(posedge clk);
      #1 data[0] = 8'hC3;
      for (int t = 0; t <= s2 + fl + 2 * CYC; t++) begin
         @(negedge clk);
         if (t == drop_t) valid[0] = 1'b0;
         checks++;
         if (tx[0] !== exp_b2b(t, s2)) begin
            failures++;
            $display("FAIL b2b_line t=%0d: got %b required %b", t, tx[0], exp_b2b(t, s2));
         end
         checks++;
         if (done[0] !== (t == fl || t == s2 + fl)) begin
            failures++;
            $display("FAIL b2b_done t=%0d: got %b required %b", t, done[0], (t == fl || t == s2 + fl));
         end
      end
      checks++;
      if (busy[0] !== 1'b0) begin
         failures++;
         $display("FAIL b2b_no_third_frame: busy=%b required 0", busy[0]);
      end
   endtask

   task automatic test_reset_mid_frame;
      @(negedge clk);
      data[0]  = 8'h55;
      valid[0] = 1'b1;
      @(posedge clk);
      #1 valid[0] = 1'b0;
      repeat (2 * CYC + 1) @(negedge clk);
      checks++;
      if (tx[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_frame_bit1: got %b required 0", tx[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({tx[0], ready[0], busy[0], done[0]} !== 4'b1100) begin
         failures++;
         $display("FAIL async_reset: tx/ready/busy/done=%b required 1100", {tx[0], ready[0], busy[0], done[0]});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 12 * CYC; t++) begin
         @(negedge clk);
         checks++;
         if ({tx[0], busy[0], done[0]} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle t=%0d: tx/busy/done=%b required 100", t, {tx[0], busy[0], done[0]});
         end
      end
      send_frame(0, 8'h55);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      valid    = '0;
      for (int k = 0; k < 3; k++) data[k] = '0;
      test_reset;
      test_frames;
      test_back_to_back;
      test_reset_mid_frame;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises parallel bytes onto a UART line: one start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit. Frame format and baud math match the UART receiver already in the design, so the two can be looped back directly. Sits between the CPU's I/O write path (valid/ready byte handshake) and the board TX pin.

## Interface
- CLK_FRE, 100: system clock frequency in MHz.
- DATA_WIDTH, 8: data bits per frame, legal range 1..15.
- PARITY_ON, 0: 1 inserts a parity bit after the data bits, 0 omits it.
- PARITY_TYPE, 0: 1 selects odd parity, 0 selects even parity.
- BAUD_RATE, 9600: line rate in bit/s.

Ports:
- i_clk_sys  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_tx_valid  in  1  byte offered on i_tx_data.
- i_tx_data  in  DATA_WIDTH  byte to send.
- o_tx_ready  out  1  block accepts a byte this cycle.
- o_uart_tx  out  1  serial line output, idle high, registered.
- o_tx_busy  out  1  a frame is on the line.
- o_tx_done  out  1  one-cycle pulse when a frame's stop bit completes.

## Operation
- CYCLE = CLK_FRE*1000000/BAUD_RATE, using integer division. A 32-bit baud counter runs 0..CYCLE-1, and every line bit lasts exactly CYCLE clocks.
- Accept: a byte is transferred on the rising edge where i_tx_valid && o_tx_ready. The data is captured into a shift register on that edge. Later changes to i_tx_data are ignored. i_tx_valid while o_tx_ready=0 is ignored and not queued.
- States:
  - IDLE: line high, o_tx_ready=1. Goes to START on accept.
  - START: line 0 for CYCLE clocks, then goes to DATA.
  - DATA: DATA_WIDTH bits, LSB first, each held CYCLE clocks. A 4-bit counter counts the bits. After the last bit, goes to PARITY if PARITY_ON, else STOP.
  - PARITY: drives (^data) ^ PARITY_TYPE for CYCLE clocks, then goes to STOP.
  - STOP: line 1 for CYCLE clocks, then goes to IDLE (or START, see Configuration).
- o_tx_busy = state != IDLE.
- Illegal state encodings recover to IDLE with line high.

## Timing
- Reset values: o_uart_tx=1, o_tx_ready=1, o_tx_busy=0, o_tx_done=0. State is IDLE, counters are 0, shift register is 0.
- Accept at edge N: o_uart_tx falls at edge N, and o_tx_ready/o_tx_busy update at edge N.
- The start bit occupies edges N..N+CYCLE-1.
- Frame length is (2 + DATA_WIDTH + PARITY_ON) * CYCLE clocks exactly.
- o_tx_done is high for exactly one clock: the first clock after the stop bit's CYCLE clocks end, the same edge where the state leaves STOP.
- Without the buffer, the earliest next accept is the IDLE cycle after the frame, so the line stays idle-high for at least 1 clock between frames.
- Reset mid-frame:
  - o_uart_tx returns to 1 immediately (asynchronous).
  - The frame is abandoned and no o_tx_done is generated.
  - After release, the block is in IDLE.

## Configuration
- Macro: UART_TX_BUF_EN.
- Defined: adds a one-entry holding register.
  - o_tx_ready = holding register empty, independent of state, so a byte may be accepted mid-frame.
  - At the end of STOP, if the holding register is full, its contents load into the shift register and the state goes directly to START. The start bit begins on the same edge o_tx_done pulses, giving zero idle gap.
  - If a byte is accepted in IDLE with the holding register empty, it goes straight to the shift register.
  - Simultaneous accept and load on the same edge is legal: the new byte lands in the holding register.
  - Reset clears the holding register.
- Undefined: no holding register, and o_tx_ready = (state == IDLE).

## Test plan
- CLK_FRE=100, BAUD_RATE=9600 (CYCLE=10416), 8N1, send 0xA5. Required line sequence: 0,1,0,1,0,0,1,0,1,1, each bit 10416 clocks. o_tx_done pulses once, 104160 clocks after accept.
- PARITY_ON=1, send 0xA5. With PARITY_TYPE=0 the parity bit is 0; with PARITY_TYPE=1 it is 1. Frame length is 114576 clocks.
- Hold i_tx_valid high continuously with data 0x3C then 0xC3:
  - Buffer off: exactly 2 frames, with one idle-high clock between them, and no bytes lost or duplicated.
  - UART_TX_BUF_EN on: the second start bit begins on the o_tx_done edge of the first frame.
- Toggle i_tx_data during a frame. The line reflects only the byte captured at accept, and ready stays 0 (buffer off).
- Assert i_rst mid-DATA. o_uart_tx=1 on the same edge, no o_tx_done pulse, and after release a fresh 0x55 frame is sent correctly.
- Loopback to the existing UART receiver (same parameters) for bytes 0x00, 0xFF, 0x5A with parity on and off. The received byte equals the sent byte, and the parity LED is high when parity is on.
